// File: rtl/mul_seq_param_if.sv
// Handshake, operand/result and shared-adder signals for mul_seq_param.
// master = requester/environment side (also drives the external adder result), slave = multiplier.
interface mul_seq_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic                   signed_i;
    logic [WIDTH-1:0]       a_i;
    logic [WIDTH-1:0]       b_i;
    logic [2*WIDTH-1:0]     result;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     sum_in_a;
    logic [2*WIDTH-1:0]     sum_in_b;
    logic [2*WIDTH-1:0]     sum_out;

    modport master (
        output start, signed_i, a_i, b_i, sum_out,
        input  result, busy, done, sum_in_a, sum_in_b
    );

    modport slave (
        input  start, signed_i, a_i, b_i, sum_out,
        output result, busy, done, sum_in_a, sum_in_b
    );
endinterface

// File: rtl/mul_seq_param.sv
// Sequential shift-add multiplier (unsigned or two's complement) using an external shared adder.
// Define MUL_SEQ_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are zero.
module mul_seq_param #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    mul_seq_param_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   OneW = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] OneP = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0]    OneC = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0]    LastC = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CntW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH-1:0]     w_mplier_shr;
    logic [2*WIDTH-1:0]   w_addend;

    // Magnitudes; the most negative value maps onto 2^(WIDTH-1) as an unsigned pattern.
    always_comb begin
        w_abs_a = bus.a_i;
        w_abs_b = bus.b_i;
        if (bus.signed_i && bus.a_i[WIDTH-1]) w_abs_a = ~bus.a_i + OneW;
        if (bus.signed_i && bus.b_i[WIDTH-1]) w_abs_b = ~bus.b_i + OneW;
    end

    assign w_mplier_shr = r_mplier >> 1;
    assign w_addend     = {{WIDTH{1'b0}}, r_mcand} << r_cnt;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
`ifdef MUL_SEQ_EARLY_TERM_EN
                    w_state_next = (w_abs_b == '0) ? StFix : StRun;
`else
                    w_state_next = StRun;
`endif
                end
            end
            StRun: begin
`ifdef MUL_SEQ_EARLY_TERM_EN
                if (w_mplier_shr == '0) w_state_next = StFix;
`else
                if (r_cnt == LastC) w_state_next = StFix;
`endif
            end
            StFix:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                StRun: begin
                    r_acc    <= bus.sum_out;
                    r_mplier <= w_mplier_shr;
                    r_cnt    <= r_cnt + OneC;
                end
                StFix: begin
                    r_result <= r_neg ? (~r_acc + OneP) : r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Adder inputs are quiet outside RUN so the shared adder sees no spurious activity.
    assign bus.sum_in_a = (r_state == StRun) ? r_acc : '0;
    assign bus.sum_in_b = ((r_state == StRun) && r_mplier[0]) ? w_addend : '0;

    assign bus.result = r_result;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule
